alu_muldiv_seq: RTL and testbench
=================================

// Module: alu_muldiv_seq
// PURPOSE
//  Multi-cycle integer multiply/divide unit with architectural HI/LO registers, companion to the
//  combinational ALU in the EX stage. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO with a start/busy/done
//  handshake. Computes 1 bit/cycle (shift-add multiply, restoring divide). Pipeline control stalls
//  any MFHI/MFLO or new mul/div while busy is high.
// PARAMETERS
//  WIDTH  32  operand width; hi/lo are WIDTH each; product is 2*WIDTH. Even, >= 4.
// PORTS
//  clk     in   1      clock, all state updates on rising edge
//  rst     in   1      synchronous reset, active-high
//  start   in   1      issue op with operands; accepted only when busy==0
//  op      in   3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//  src_x   in   WIDTH  multiplicand / dividend / MTHI-MTLO data
//  src_y   in   WIDTH  multiplier / divisor
//  flush   in   1      cancel in-flight op (pipeline flush); hi/lo keep prior values
//  busy    out  1      iterative op in progress
//  done    out  1      one-cycle pulse: hi/lo updated this cycle
//  hi      out  WIDTH  HI register (product upper half / remainder)
//  lo      out  WIDTH  LO register (product lower half / quotient)
// BEHAVIOUR
//  Reset: state IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0, internal regs=0.
//  States: IDLE -> RUN (start & op in 0..3) ; RUN -> FIN (counter==WIDTH-1) ; FIN -> IDLE.
//  - IDLE: start & op 0..3 at edge E0 latches |x|,|y| (signed ops) or raw (unsigned), result sign
//    flags, counter=0; busy=1 from E0. start & op 4/5: hi (4) or lo (5) <= src_x at E0, done=1
//    for the following cycle, busy stays 0. op 6/7 or start=0: nothing happens.
//  - RUN: one iteration per edge, E1..E_WIDTH. Multiply: add multiplicand to upper accumulator
//    if current multiplier LSB set, shift right. Divide: shift remainder left, trial-subtract
//    divisor, set quotient bit if non-negative.
//  - At E_WIDTH: apply sign fix-up, write hi/lo, busy<=0, done<=1 (state FIN), done<=0 at next edge.
//  - Latency: start edge E0 -> hi/lo valid and done high in cycle after E_WIDTH (WIDTH+1 cycles).
//  - start while busy=1: ignored, no effect on operation or outputs.
//  - start in FIN cycle: accepted (FIN treated as IDLE for acceptance); done still pulses once.
//  Arithmetic:
//  - MULT/MULTU: {hi,lo} = x*y, signed product negated (2*WIDTH two's complement) if signs differ.
//  - DIV/DIVU: lo = quotient truncated toward zero, hi = remainder with sign of dividend.
//  - Divide by zero (both signedness): lo = all ones, hi = src_x unchanged. Same latency.
//  - Signed overflow MIN / -1: lo = MIN (0x8000_0000 @32), hi = 0.
//  flush: if 1 at an edge, state<=IDLE, busy<=0, done<=0, hi/lo not written; flush has priority
//  over start in the same cycle (start dropped). flush in IDLE: no effect.
//  rst overrides flush and start; reset mid-RUN discards op, hi/lo <= 0.
// CONFIGURATION
//  MULDIV_FAST_MUL_EN defined: MULT/MULTU use a single-cycle WIDTH x WIDTH multiplier; at E0 hi/lo
//  are written, busy stays 0, done pulses in the next cycle (same timing as MTHI/MTLO). Division
//  stays iterative. Not defined: multiply iterative, WIDTH+1 cycles as above. Ports identical.
// TESTING
//  1 MULTU x=0xFFFF_FFFF y=0xFFFF_FFFF -> after 33 cycles done=1, hi=0xFFFF_FFFE, lo=0x0000_0001.
//  2 MULT x=-3 (0xFFFF_FFFD) y=7 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFEB; DIV x=-7 y=2 -> lo=0xFFFF_FFFD
//    (-3), hi=0xFFFF_FFFF (-1); DIVU x=100 y=7 -> lo=14, hi=2.
//  3 DIV x=0x8000_0000 y=0xFFFF_FFFF -> lo=0x8000_0000, hi=0; DIVU x=5 y=0 -> lo=0xFFFF_FFFF, hi=5.
//  4 hi=lo=0x1234 preset via MTHI/MTLO (done pulses 1 cycle each); start DIVU then flush at
//    cycle 10 -> busy=0 next cycle, done never pulses, hi/lo stay 0x1234.
//  5 Second start (MULTU 2*2) while busy ignored: first result only, single done; start in FIN
//    cycle accepted back-to-back -> second done exactly 33 cycles after first.
//  6 rst asserted at cycle 15 of a DIV -> busy=0, done=0, hi=lo=0 next cycle; with
//    MULDIV_FAST_MUL_EN, MULTU 6*7 -> lo=42, hi=0, busy never 1, done next cycle.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers, 1 bit per cycle.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiply, division stays iterative.
module alu_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] src_x_i,
    input  logic [WIDTH-1:0] src_y_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MULT = 3'd0;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;     // upper product half / partial remainder
    logic [WIDTH-1:0] mq_q, mq_d;       // multiplier / dividend shifting into quotient
    logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand / divisor magnitude
    logic             div_q, div_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic             signed_op, x_neg, y_neg, accept;
    logic [WIDTH-1:0] abs_x, abs_y;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] acc_it, mq_it;
    logic [2*WIDTH-1:0] prod_it, prod_fix;
    logic [WIDTH-1:0] quot_fix, rem_fix;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] ext_x, ext_y, fast_prod;
    // Sign-extending to 2*WIDTH makes the modular unsigned product equal the signed one
    always_comb begin
        ext_x     = {{WIDTH{x_neg}}, src_x_i};
        ext_y     = {{WIDTH{y_neg}}, src_y_i};
        fast_prod = ext_x * ext_y;
    end
`endif

    always_comb begin
        signed_op = (op_i == OP_MULT) || (op_i == OP_DIV);
        x_neg     = signed_op && src_x_i[WIDTH-1];
        y_neg     = signed_op && src_y_i[WIDTH-1];
        abs_x     = x_neg ? -src_x_i : src_x_i;
        abs_y     = y_neg ? -src_y_i : src_y_i;
        accept    = start_i && (state_q != S_RUN);

        mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        div_shift = {acc_q, mq_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ok    = ~div_diff[WIDTH];

        if (div_q) begin
            acc_it = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            mq_it  = {mq_q[WIDTH-2:0], div_ok};
        end else begin
            acc_it = mul_sum[WIDTH:1];
            mq_it  = {mul_sum[0], mq_q[WIDTH-1:1]};
        end

        prod_it  = {acc_it, mq_it};
        prod_fix = neg_q ? -prod_it : prod_it;
        quot_fix = dz_q ? {WIDTH{1'b1}} : (neg_q ? -mq_it : mq_it);
        rem_fix  = rneg_q ? -acc_it : acc_it;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        opnd_d  = opnd_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_RUN: begin
                    acc_d = acc_it;
                    mq_d  = mq_it;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH-1)) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                        if (div_q) begin
                            hi_d = rem_fix;
                            lo_d = quot_fix;
                        end else begin
                            hi_d = prod_fix[2*WIDTH-1:WIDTH];
                            lo_d = prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    if (accept) begin
                        if (op_i == OP_MTHI) begin
                            hi_d   = src_x_i;
                            done_d = 1'b1;
                        end else if (op_i == OP_MTLO) begin
                            lo_d   = src_x_i;
                            done_d = 1'b1;
                        end else if (!op_i[2]) begin
`ifdef MULDIV_FAST_MUL_EN
                            if (!op_i[1]) begin
                                hi_d   = fast_prod[2*WIDTH-1:WIDTH];
                                lo_d   = fast_prod[WIDTH-1:0];
                                done_d = 1'b1;
                            end else begin
`else
                            begin
`endif
                                state_d = S_RUN;
                                cnt_d   = '0;
                                acc_d   = '0;
                                div_d   = op_i[1];
                                mq_d    = op_i[1] ? abs_x : abs_y;
                                opnd_d  = op_i[1] ? abs_y : abs_x;
                                neg_d   = x_neg ^ y_neg;
                                rneg_d  = x_neg;
                                dz_d    = op_i[1] && (src_y_i == '0);
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            opnd_q  <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            opnd_q  <= opnd_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = (state_q == S_RUN);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed-vector bench for alu_muldiv_seq (WIDTH=32); honours MULDIV_FAST_MUL_EN timing.
module tb_alu_muldiv_seq;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    op = 3'd0;
    logic [W-1:0]  src_x = '0;
    logic [W-1:0]  src_y = '0;
    logic          flush = 1'b0;
    logic          busy, done;
    logic [W-1:0]  hi, lo;

    int n_vec = 0;
    int n_err = 0;

    alu_muldiv_seq #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
        .src_x_i(src_x), .src_y_i(src_y), .flush_i(flush),
        .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
    );

    always #5 clk = ~clk;

    // Issues one op at a negedge and returns at the negedge where done is seen (or timeout)
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] rhi, output logic [W-1:0] rlo,
                          output int lat, output logic saw_busy);
        @(negedge clk);
        start = 1'b1; op = o; src_x = x; src_y = y;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        saw_busy = busy;
        while (done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
            saw_busy = saw_busy | busy;
        end
        rhi = hi;
        rlo = lo;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", done); end
        n_vec++; if (hi !== '0) begin n_err++; $display("FAIL reset_hi got %h exp 0", hi); end
        n_vec++; if (lo !== '0) begin n_err++; $display("FAIL reset_lo got %h exp 0", lo); end
        rst = 1'b0;
    endtask

    typedef struct {
        logic [2:0]   o;
        logic [W-1:0] x, y, ehi, elo;
    } vec_t;

    task automatic test_mul;
        vec_t v [5];
        logic [W-1:0] rhi, rlo;
        int lat;
        logic sb;
        v[0] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        v[1] = '{3'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
        v[2] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        v[3] = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        v[4] = '{3'd1, 32'd6,         32'd7,         32'h0000_0000, 32'd42};
        for (int i = 0; i < 5; i++) begin
            run_op(v[i].o, v[i].x, v[i].y, rhi, rlo, lat, sb);
            n_vec++; if (rhi !== v[i].ehi) begin n_err++; $display("FAIL mul%0d_hi got %h exp %h", i, rhi, v[i].ehi); end
            n_vec++; if (rlo !== v[i].elo) begin n_err++; $display("FAIL mul%0d_lo got %h exp %h", i, rlo, v[i].elo); end
            n_vec++; if (lat != (FAST ? 1 : 33)) begin n_err++; $display("FAIL mul%0d_latency got %0d exp %0d", i, lat, FAST ? 1 : 33); end
            n_vec++; if (sb !== !FAST) begin n_err++; $display("FAIL mul%0d_busy got %b exp %b", i, sb, !FAST); end
        end
    endtask

    task automatic test_div;
        vec_t v [7];
        logic [W-1:0] rhi, rlo;
        int lat;
        logic sb;
        v[0] = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        v[1] = '{3'd3, 32'd100,       32'd7,         32'd2,         32'd14};
        v[2] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        v[3] = '{3'd3, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
        v[4] = '{3'd2, 32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF};
        v[5] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        v[6] = '{3'd3, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF};
        for (int i = 0; i < 7; i++) begin
            run_op(v[i].o, v[i].x, v[i].y, rhi, rlo, lat, sb);
            n_vec++; if (rhi !== v[i].ehi) begin n_err++; $display("FAIL div%0d_hi got %h exp %h", i, rhi, v[i].ehi); end
            n_vec++; if (rlo !== v[i].elo) begin n_err++; $display("FAIL div%0d_lo got %h exp %h", i, rlo, v[i].elo); end
            n_vec++; if (lat != 33) begin n_err++; $display("FAIL div%0d_latency got %0d exp 33", i, lat); end
            n_vec++; if (sb !== 1'b1) begin n_err++; $display("FAIL div%0d_busy got %b exp 1", i, sb); end
        end
    endtask

    task automatic test_flush;
        logic [W-1:0] rhi, rlo;
        int lat;
        logic sb, seen;
        run_op(3'd4, 32'h1234, 32'd0, rhi, rlo, lat, sb);
        n_vec++; if (lat != 1 || sb !== 1'b0) begin n_err++; $display("FAIL mthi_timing got lat %0d busy %b exp 1 0", lat, sb); end
        run_op(3'd5, 32'h1234, 32'd0, rhi, rlo, lat, sb);
        n_vec++; if (lat != 1 || sb !== 1'b0) begin n_err++; $display("FAIL mtlo_timing got lat %0d busy %b exp 1 0", lat, sb); end
        n_vec++; if (rhi !== 32'h1234 || rlo !== 32'h1234) begin n_err++; $display("FAIL mthi_mtlo got %h %h exp 1234 1234", rhi, rlo); end
        @(negedge clk);
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL mtlo_pulse got %b exp 0", done); end
        start = 1'b1; op = 3'd3; src_x = 32'd100; src_y = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL flush_prebusy got %b exp 1", busy); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL flush_stop got busy %b done %b exp 0 0", busy, done); end
        seen = 1'b0;
        repeat (40) begin @(negedge clk); seen = seen | done | busy; end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_nodone got %b exp 0", seen); end
        n_vec++; if (hi !== 32'h1234 || lo !== 32'h1234) begin n_err++; $display("FAIL flush_keep got %h %h exp 1234 1234", hi, lo); end
        start = 1'b1; op = 3'd4; src_x = 32'hBEEF; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        n_vec++; if (done !== 1'b0 || hi !== 32'h1234) begin n_err++; $display("FAIL flush_prio got done %b hi %h exp 0 1234", done, hi); end
    endtask

    task automatic test_reset_mid;
        logic seen;
        @(negedge clk);
        start = 1'b1; op = 3'd2; src_x = 32'hFFFF_FFF9; src_y = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL rstmid_ctl got busy %b done %b exp 0 0", busy, done); end
        n_vec++; if (hi !== '0 || lo !== '0) begin n_err++; $display("FAIL rstmid_hilo got %h %h exp 0 0", hi, lo); end
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin @(negedge clk); seen = seen | done | busy; end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL rstmid_quiet got %b exp 0", seen); end
    endtask

    task automatic test_back_to_back;
        int lat, ndone;
        logic sb;
        @(negedge clk);
        start = 1'b1; op = 3'd3; src_x = 32'd100; src_y = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 3'd1; src_x = 32'd2; src_y = 32'd2;
        @(negedge clk);
        start = 1'b0;
        lat = 6;
        ndone = 0;
        while (done !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
        n_vec++; if (lat != 33) begin n_err++; $display("FAIL b2b_first_latency got %0d exp 33", lat); end
        n_vec++; if (hi !== 32'd2 || lo !== 32'd14) begin n_err++; $display("FAIL b2b_first_result got %h %h exp 2 e", hi, lo); end
        start = 1'b1; op = 3'd3; src_x = 32'd1000; src_y = 32'd10;
        @(negedge clk);
        start = 1'b0;
        n_vec++; if (done !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept got done %b busy %b exp 0 1", done, busy); end
        lat = 1;
        sb = 1'b0;
        while (done !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
        ndone = (done === 1'b1) ? 1 : 0;
        @(negedge clk);
        if (done === 1'b1) ndone++;
        n_vec++; if (lat != 33) begin n_err++; $display("FAIL b2b_second_spacing got %0d exp 33", lat); end
        n_vec++; if (hi !== 32'd0 || lo !== 32'd100) begin n_err++; $display("FAIL b2b_second_result got %h %h exp 0 64", hi, lo); end
        n_vec++; if (ndone != 1 || sb !== 1'b0) begin n_err++; $display("FAIL b2b_single_done got %0d exp 1", ndone); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
